// File: rtl/cps_pkg.sv
// Shared types and constants for the code-phase search block.
package cps_pkg;

  localparam int SCORE_W = 9;
  // Most negative 9-bit signed value (-256); seeds the best-score tracker.
  localparam logic signed [SCORE_W-1:0] SCORE_MIN = 9'h100;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    INTEGRATE,
    EVAL,
    SLIP,
    DONE
  } state_t;

endpackage

// File: rtl/cps_window_timer.sv
// Integration window timer: load arms a WIN_LEN-cycle window, count steps it,
// expire flags the final counted cycle.
module cps_window_timer #(
  parameter int WIN_LEN = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  logic [7:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= 8'(WIN_LEN - 1);
    end else if (count && cnt != '0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expire = count && (cnt == '0);

endmodule

// File: rtl/code_phase_search.sv
// Serial code-phase search: integrates each phase for WIN_LEN cycles and keeps
// the best score. Define CPS_EARLY_LOCK_EN to stop at the first phase >= THRESH.
module code_phase_search
  import cps_pkg::*;
#(
  parameter int WIN_LEN    = 200,
  parameter int NUM_PHASES = 31,
  parameter int THRESH     = 40,
  localparam int PH_W      = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [7:0]                match_cnt,
  input  logic [7:0]                miss_cnt,
  output logic                      corr_clr,
  output logic                      code_slip,
  output logic                      busy,
  output logic                      done,
  output logic                      locked,
  output logic [PH_W-1:0]           best_phase,
  output logic signed [SCORE_W-1:0] best_score
);

  localparam logic signed [SCORE_W-1:0] THRESH_S   = SCORE_W'(THRESH);
  localparam logic [PH_W-1:0]           LAST_PHASE = PH_W'(NUM_PHASES - 1);

  state_t                      state, state_next;
  logic [PH_W-1:0]             phase_idx;
  logic signed [SCORE_W-1:0]   score;
  logic                        better;
  logic                        early_hit;
  logic                        win_load, win_count, win_expire;

  assign score  = $signed({1'b0, match_cnt}) - $signed({1'b0, miss_cnt});
  assign better = score > best_score;

`ifdef CPS_EARLY_LOCK_EN
  assign early_hit = score >= THRESH_S;
`else
  assign early_hit = 1'b0;
`endif

  cps_window_timer #(.WIN_LEN(WIN_LEN)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (win_load),
    .count (win_count),
    .expire(win_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    corr_clr   = 1'b0;
    code_slip  = 1'b0;
    done       = 1'b0;
    win_load   = 1'b0;
    win_count  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:      if (start) state_next = CLEAR;
      CLEAR: begin
        corr_clr   = 1'b1;
        win_load   = 1'b1;
        state_next = INTEGRATE;
      end
      INTEGRATE: begin
        win_count = 1'b1;
        if (win_expire) state_next = EVAL;
      end
      EVAL:      state_next = (phase_idx == LAST_PHASE || early_hit) ? DONE : SLIP;
      SLIP: begin
        code_slip  = 1'b1;
        state_next = CLEAR;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
  end

  // Result registers hold through IDLE and are only re-seeded by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_idx  <= '0;
      best_score <= '0;
      best_phase <= '0;
      locked     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          phase_idx  <= '0;
          best_score <= SCORE_MIN;
          best_phase <= '0;
          locked     <= 1'b0;
        end
        EVAL: if (better) begin
          best_score <= score;
          best_phase <= phase_idx;
        end
        SLIP:    phase_idx <= phase_idx + 1'b1;
        DONE:    locked    <= (best_score >= THRESH_S);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/code_phase_search.md
CODE_PHASE_SEARCH -- requirements
Module: code_phase_search

Interface
REQ-001 Parameter WIN_LEN, default 200, integration window length in clk cycles; SHALL be in 1..255 so the 8-bit correlator counters cannot wrap.
REQ-002 Parameter NUM_PHASES, default 31, number of code phases scanned per search.
REQ-003 Parameter THRESH, default 40, minimum signed score required to declare lock.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a search; honoured only in IDLE.
REQ-007 match_cnt  in  8  correlator match count.
REQ-008 miss_cnt  in  8  correlator miss count.
REQ-009 corr_clr  out  1  synchronous clear to the correlator, active high.
REQ-010 code_slip  out  1  one-cycle pulse; the code generator shall retard its code by one chip.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse at search end.
REQ-013 locked  out  1  search result valid and above threshold.
REQ-014 best_phase  out  $clog2(NUM_PHASES)  phase index of the best score.
REQ-015 best_score  out  9  signed best score (match minus miss).

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, INTEGRATE, EVAL, SLIP and DONE.
REQ-017 IDLE with start=1 SHALL go to CLEAR, zero phase_idx, set best_score to -256, clear locked and zero best_phase.
REQ-018 CLEAR SHALL assert corr_clr for exactly one cycle, then go to INTEGRATE.
REQ-019 INTEGRATE SHALL last exactly WIN_LEN cycles, with corr_clr=0, then go to EVAL.
REQ-020 EVAL SHALL compute score = {1'b0,match_cnt} - {1'b0,miss_cnt} as a 9-bit signed value, sampled in the EVAL cycle.
REQ-021 EVAL SHALL update best_score and best_phase only if score > best_score (strict); ties keep the earlier phase.
REQ-022 EVAL SHALL go to DONE if phase_idx == NUM_PHASES-1; otherwise it SHALL go to SLIP.
REQ-023 SLIP SHALL assert code_slip for one cycle, increment phase_idx, then go to CLEAR.
REQ-024 DONE SHALL pulse done for one cycle, set locked = (best_score >= THRESH), then return to IDLE.
REQ-025 Latency from start to done SHALL be NUM_PHASES*(WIN_LEN+2) + (NUM_PHASES-1) + 1 cycles.
REQ-026 start SHALL be ignored outside IDLE, including in the DONE cycle.
REQ-027 locked, best_phase and best_score SHALL hold their values in IDLE until the next accepted start.
REQ-028 code_slip and corr_clr SHALL never be asserted in the same cycle.

Reset
REQ-029 rst_n low SHALL immediately force IDLE and clear all of the following to 0: corr_clr, code_slip, busy, done, locked, best_phase, best_score, phase_idx and the window counter.
REQ-030 Reset asserted mid-search SHALL abort the search with no done pulse; the code generator phase is not restored.

Configuration
REQ-031 With CPS_EARLY_LOCK_EN defined, EVAL SHALL go directly to DONE when score >= THRESH, reporting that phase even if it is not the global maximum.
REQ-032 Without CPS_EARLY_LOCK_EN, all NUM_PHASES phases SHALL always be scanned.

Structure
REQ-033 Package cps_pkg SHALL hold the state enum, SCORE_W=9 and SCORE_MIN=-256.
REQ-034 The window counter SHALL be a sub-module, cps_window_timer, with load, count and expire signals.
REQ-035 The FSM, score subtraction and best tracking SHALL stay in code_phase_search.

Verification
REQ-036 Bench uses a correlator model plus a 31-chip LFSR code generator honouring code_slip; sig = code delayed 7 chips -> done, locked=1, best_phase=7, best_score=200.
REQ-037 sig held constant 0 -> locked=0 and best_score equal to the phase-0 score; done arrives exactly at the REQ-025 latency.
REQ-038 Two phases (3 and 9) produce an equal maximum score -> best_phase=3.
REQ-039 CPS_EARLY_LOCK_EN with THRESH=40 and target phase 5 -> done after 6 windows, best_phase=5, exactly 5 code_slip pulses.
REQ-040 rst_n pulsed low during INTEGRATE of phase 4 -> all outputs 0 and no done pulse; a following start runs a complete search.
REQ-041 start held high throughout a search -> exactly one search runs; a new one begins only from IDLE after done.
